huffman_decoder: RTL and testbench

Receive-side counterpart of the six-symbol Huffman encoder. Takes the encoder's code table (HC1..HC6 code words, M1..M6 masks) and a serial MSB-first bitstream, and emits one decoded symbol index (1..6) per completed code word with a valid/ready output handshake. Sits downstream of the encoder, or of the channel carrying its bitstream, and closes the compression loop for verification and system use.

---
 rtl/huffman_pkg.sv | 32 +++
 rtl/huffman_code_match.sv | 15 +
 rtl/huffman_decoder.sv | 193 +++++++++++++++++++
 tb/tb_huffman_decoder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared types and helpers for the six-symbol Huffman decoder.
package huffman_pkg;

  localparam int NUM_SYM = 6;
  localparam int CODE_W  = 8;
  localparam int SYM_W   = 3;
  localparam int LEN_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    HOLD
  } state_t;

  function automatic logic [LEN_W-1:0] popcount(input logic [CODE_W-1:0] m);
    logic [LEN_W-1:0] n;
    n = '0;
    for (int i = 0; i < CODE_W; i++) begin
      n = n + LEN_W'(m[i]);
    end
    return n;
  endfunction

  // A legal mask is a non-empty run of low ones no longer than max_len.
  function automatic logic mask_legal(input logic [CODE_W-1:0] m, input int max_len);
    logic [CODE_W-1:0] m_inc;
    m_inc = m + CODE_W'(1);
    return (m != '0) && ((m & m_inc) == '0) && (int'(popcount(m)) <= max_len);
  endfunction

endpackage

// File: rtl/huffman_code_match.sv
// One code-table entry comparator: hits when the shifted-in bits equal the masked code word.
module huffman_code_match
  import huffman_pkg::*;
(
  input  logic [CODE_W-1:0] nsr,
  input  logic [LEN_W-1:0]  nlen,
  input  logic [CODE_W-1:0] hc,
  input  logic [CODE_W-1:0] mask,
  input  logic [LEN_W-1:0]  code_len,
  output logic              match
);

  assign match = (nlen == code_len) && ((nsr & mask) == (hc & mask));

endmodule

// File: rtl/huffman_decoder.sv
// Serial MSB-first Huffman decoder for the six-symbol encoder's table.
// Optional symbol counters CNT1..CNT6 are enabled by defining HUFFMAN_DEC_CNT_EN.
module huffman_decoder
  import huffman_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] HC1,
  input  logic [CODE_W-1:0] HC2,
  input  logic [CODE_W-1:0] HC3,
  input  logic [CODE_W-1:0] HC4,
  input  logic [CODE_W-1:0] HC5,
  input  logic [CODE_W-1:0] HC6,
  input  logic [CODE_W-1:0] M1,
  input  logic [CODE_W-1:0] M2,
  input  logic [CODE_W-1:0] M3,
  input  logic [CODE_W-1:0] M4,
  input  logic [CODE_W-1:0] M5,
  input  logic [CODE_W-1:0] M6,
  output logic              tbl_ready,
  output logic              tbl_err,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              bit_ready,
  output logic              sym_valid,
  output logic [SYM_W-1:0]  sym,
  input  logic              sym_ready,
  output logic              dec_err
`ifdef HUFFMAN_DEC_CNT_EN
  ,
  output logic [7:0]        CNT1,
  output logic [7:0]        CNT2,
  output logic [7:0]        CNT3,
  output logic [7:0]        CNT4,
  output logic [7:0]        CNT5,
  output logic [7:0]        CNT6
`endif
);

  state_t            state;
  logic [CODE_W-1:0] hc_q [NUM_SYM];
  logic [CODE_W-1:0] m_q  [NUM_SYM];
  logic [LEN_W-1:0]  l_q  [NUM_SYM];
  logic [2:0]        load_idx;
  logic              load_err;
  logic [CODE_W-1:0] sr;
  logic [LEN_W-1:0]  len;
  logic [CODE_W-1:0] nsr;
  logic [LEN_W-1:0]  nlen;
  logic [NUM_SYM-1:0] match;
  logic              hit;
  logic [SYM_W-1:0]  hit_sym;

  assign nsr  = (sr << 1) | CODE_W'(bit_in);
  assign nlen = len + LEN_W'(1);

  for (genvar g = 0; g < NUM_SYM; g++) begin : g_match
    huffman_code_match u_match (
      .nsr      (nsr),
      .nlen     (nlen),
      .hc       (hc_q[g]),
      .mask     (m_q[g]),
      .code_len (l_q[g]),
      .match    (match[g])
    );
  end

  // Descending scan so the lowest-index matching entry wins.
  always_comb begin
    hit     = 1'b0;
    hit_sym = '0;
    for (int i = NUM_SYM - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_sym = SYM_W'(i + 1);
      end
    end
  end

`ifdef HUFFMAN_DEC_CNT_EN
  logic [7:0] cnt [NUM_SYM];
  assign CNT1 = cnt[0];
  assign CNT2 = cnt[1];
  assign CNT3 = cnt[2];
  assign CNT4 = cnt[3];
  assign CNT5 = cnt[4];
  assign CNT6 = cnt[5];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tbl_ready <= 1'b0;
      tbl_err   <= 1'b0;
      bit_ready <= 1'b0;
      sym_valid <= 1'b0;
      sym       <= '0;
      dec_err   <= 1'b0;
      sr        <= '0;
      len       <= '0;
      load_idx  <= '0;
      load_err  <= 1'b0;
      for (int i = 0; i < NUM_SYM; i++) begin
        hc_q[i] <= '0;
        m_q[i]  <= '0;
        l_q[i]  <= '0;
`ifdef HUFFMAN_DEC_CNT_EN
        cnt[i]  <= '0;
`endif
      end
    end else begin
      dec_err <= 1'b0;
      if (code_valid) begin
        hc_q      <= '{HC1, HC2, HC3, HC4, HC5, HC6};
        m_q       <= '{M1, M2, M3, M4, M5, M6};
        for (int i = 0; i < NUM_SYM; i++) begin
          l_q[i] <= '0;
`ifdef HUFFMAN_DEC_CNT_EN
          cnt[i] <= '0;
`endif
        end
        load_idx  <= '0;
        load_err  <= 1'b0;
        state     <= LOAD;
        tbl_ready <= 1'b0;
        tbl_err   <= 1'b0;
        bit_ready <= 1'b0;
        sym_valid <= 1'b0;
        sr        <= '0;
        len       <= '0;
      end else begin
        case (state)
          IDLE: ;
          // One entry per cycle, then a final cycle to publish the verdict.
          LOAD: begin
            if (load_idx == 3'(NUM_SYM)) begin
              if (load_err) begin
                tbl_err <= 1'b1;
                state   <= IDLE;
              end else begin
                tbl_ready <= 1'b1;
                bit_ready <= 1'b1;
                state     <= RUN;
              end
            end else begin
              l_q[load_idx] <= popcount(m_q[load_idx]);
              if (!mask_legal(m_q[load_idx], MAX_LEN)) begin
                load_err <= 1'b1;
              end
              load_idx <= load_idx + 3'd1;
            end
          end
          RUN: begin
            if (bit_valid && bit_ready) begin
              if (hit) begin
                sym       <= hit_sym;
                sym_valid <= 1'b1;
                bit_ready <= 1'b0;
                sr        <= '0;
                len       <= '0;
                state     <= HOLD;
              end else if (nlen == LEN_W'(MAX_LEN)) begin
                dec_err <= 1'b1;
                sr      <= '0;
                len     <= '0;
              end else begin
                sr  <= nsr;
                len <= nlen;
              end
            end
          end
          HOLD: begin
            if (sym_ready) begin
              sym_valid <= 1'b0;
              bit_ready <= 1'b1;
              state     <= RUN;
`ifdef HUFFMAN_DEC_CNT_EN
              if (cnt[sym - 3'd1] != 8'hFF) begin
                cnt[sym - 3'd1] <= cnt[sym - 3'd1] + 8'd1;
              end
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: default-length instance plus a MAX_LEN=4 instance.
module tb_huffman_decoder;

  typedef struct {
    logic       b;
    logic [2:0] expSym;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid, code_valid4;
  logic [7:0] hc [6];
  logic [7:0] m  [6];
  logic       bit_valid, bit_valid4, bit_in;
  logic       sym_ready, sym_ready4;

  logic       tbl_ready, tbl_err, bit_ready, sym_valid, dec_err;
  logic [2:0] sym;
  logic       tbl_ready4, tbl_err4, bit_ready4, sym_valid4, dec_err4;
  logic [2:0] sym4;
`ifdef HUFFMAN_DEC_CNT_EN
  logic [7:0] cnt1, cnt2, cnt3, cnt4, cnt5, cnt6;
  logic [7:0] cntb1, cntb2, cntb3, cntb4, cntb5, cntb6;
`endif

  int         testsRun = 0;
  int         testsFailed = 0;
  logic [2:0] expQ [$];

  logic [7:0] goodHc [6] = '{8'h01, 8'h01, 8'h00, 8'h03, 8'h05, 8'h04};
  logic [7:0] goodM  [6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
  logic [7:0] shortHc [6] = '{8'h01, 8'h01, 8'h00, 8'h03, 8'h03, 8'h03};
  logic [7:0] shortM  [6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0F, 8'h0F};

  always #5 clk = ~clk;

  huffman_decoder dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(hc[0]), .HC2(hc[1]), .HC3(hc[2]), .HC4(hc[3]), .HC5(hc[4]), .HC6(hc[5]),
    .M1(m[0]), .M2(m[1]), .M3(m[2]), .M4(m[3]), .M5(m[4]), .M6(m[5]),
    .tbl_ready(tbl_ready), .tbl_err(tbl_err),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready), .dec_err(dec_err)
`ifdef HUFFMAN_DEC_CNT_EN
    , .CNT1(cnt1), .CNT2(cnt2), .CNT3(cnt3), .CNT4(cnt4), .CNT5(cnt5), .CNT6(cnt6)
`endif
  );

  huffman_decoder #(.MAX_LEN(4)) dut4 (
    .clk(clk), .reset(reset), .code_valid(code_valid4),
    .HC1(hc[0]), .HC2(hc[1]), .HC3(hc[2]), .HC4(hc[3]), .HC5(hc[4]), .HC6(hc[5]),
    .M1(m[0]), .M2(m[1]), .M3(m[2]), .M4(m[3]), .M5(m[4]), .M6(m[5]),
    .tbl_ready(tbl_ready4), .tbl_err(tbl_err4),
    .bit_valid(bit_valid4), .bit_in(bit_in), .bit_ready(bit_ready4),
    .sym_valid(sym_valid4), .sym(sym4), .sym_ready(sym_ready4), .dec_err(dec_err4)
`ifdef HUFFMAN_DEC_CNT_EN
    , .CNT1(cntb1), .CNT2(cntb2), .CNT3(cntb3), .CNT4(cntb4), .CNT5(cntb5), .CNT6(cntb6)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulses code_valid on the chosen instance; returns 1 time unit after load edge N.
  task automatic applyStimulus(input bit useDut4);
    if (useDut4) code_valid4 = 1'b1;
    else code_valid = 1'b1;
    @(posedge clk);
    #1;
    code_valid  = 1'b0;
    code_valid4 = 1'b0;
  endtask

  task automatic sendBit(input logic b);
    int k;
    k = 0;
    while (!bit_ready && k < 20) begin
      waitCycles(1);
      k++;
    end
    if (!bit_ready) begin
      checkOutput("bit_ready timeout", bit_ready, 1);
    end else begin
      bit_valid = 1'b1;
      bit_in    = b;
      waitCycles(1);
      bit_valid = 1'b0;
    end
  endtask

  task automatic sendBit4(input logic b);
    int k;
    k = 0;
    while (!bit_ready4 && k < 20) begin
      waitCycles(1);
      k++;
    end
    if (!bit_ready4) begin
      checkOutput("bit_ready4 timeout", bit_ready4, 1);
    end else begin
      bit_valid4 = 1'b1;
      bit_in     = b;
      waitCycles(1);
      bit_valid4 = 1'b0;
    end
  endtask

  // Every symbol handshake on the main instance is matched against the queue.
  always @(negedge clk) begin
    if (reset && sym_valid && sym_ready) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected handshake: got sym %0d, expected none", sym);
      end else begin
        checkOutput("scoreboard sym", {29'd0, sym}, {29'd0, expQ.pop_front()});
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t streamVec [11];
    streamVec = '{'{1'b1, 3'd1}, '{1'b0, 3'd0}, '{1'b1, 3'd2}, '{1'b0, 3'd0},
                  '{1'b0, 3'd0}, '{1'b0, 3'd3}, '{1'b0, 3'd0}, '{1'b0, 3'd0},
                  '{1'b1, 3'd0}, '{1'b0, 3'd0}, '{1'b0, 3'd6}};

    reset = 1'b0; code_valid = 1'b0; code_valid4 = 1'b0;
    bit_valid = 1'b0; bit_valid4 = 1'b0; bit_in = 1'b0;
    sym_ready = 1'b1; sym_ready4 = 1'b1;
    hc = goodHc; m = goodM;

    waitCycles(3);
    checkOutput("reset tbl_ready", tbl_ready, 0);
    checkOutput("reset tbl_err", tbl_err, 0);
    checkOutput("reset bit_ready", bit_ready, 0);
    checkOutput("reset sym_valid", sym_valid, 0);
    checkOutput("reset sym", sym, 0);
    checkOutput("reset dec_err", dec_err, 0);
    reset = 1'b1;
    waitCycles(1);

    applyStimulus(0);
    checkOutput("load tbl_ready at N", tbl_ready, 0);
    waitCycles(6);
    checkOutput("load tbl_ready at N+6", tbl_ready, 0);
    waitCycles(1);
    checkOutput("load tbl_ready at N+7", tbl_ready, 1);
    checkOutput("load tbl_err", tbl_err, 0);
    checkOutput("load bit_ready", bit_ready, 1);

    for (int i = 0; i < 11; i++) begin
      sendBit(streamVec[i].b);
      if (streamVec[i].expSym != 3'd0) begin
        checkOutput("stream sym_valid", sym_valid, 1);
        checkOutput("stream sym", {29'd0, sym}, {29'd0, streamVec[i].expSym});
        expQ.push_back(streamVec[i].expSym);
      end else begin
        checkOutput("stream no sym", sym_valid, 0);
      end
    end
    waitCycles(1);
    checkOutput("hold one cycle sym_valid", sym_valid, 0);
    checkOutput("hold one cycle bit_ready", bit_ready, 1);

    // Backpressure: symbol 4 held while stray bits are offered.
    sym_ready = 1'b0;
    sendBit(1'b0); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
    checkOutput("bp sym_valid", sym_valid, 1);
    checkOutput("bp sym", sym, 4);
    expQ.push_back(3'd4);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      waitCycles(1);
      checkOutput("bp held sym_valid", sym_valid, 1);
      checkOutput("bp held sym", sym, 4);
      checkOutput("bp held bit_ready", bit_ready, 0);
    end
    sym_ready = 1'b1;
    bit_valid = 1'b0;
    waitCycles(1);
    checkOutput("bp release sym_valid", sym_valid, 0);
    checkOutput("bp release bit_ready", bit_ready, 1);

    // Reload after two bits of a partial code.
    sendBit(1'b0); sendBit(1'b0);
    applyStimulus(0);
    checkOutput("midcode reload tbl_ready", tbl_ready, 0);
    waitCycles(7);
    checkOutput("midcode reload done", tbl_ready, 1);
    sendBit(1'b1);
    checkOutput("midcode fresh sym_valid", sym_valid, 1);
    checkOutput("midcode fresh sym", sym, 1);
    expQ.push_back(3'd1);
    waitCycles(1);

    // Reload while a symbol is pending drops it.
    sym_ready = 1'b0;
    sendBit(1'b0); sendBit(1'b1);
    checkOutput("hold pending sym", sym_valid, 1);
    applyStimulus(0);
    checkOutput("hold dropped sym_valid", sym_valid, 0);
    checkOutput("hold dropped tbl_ready", tbl_ready, 0);
    waitCycles(7);
    sym_ready = 1'b1;
    sendBit(1'b0); sendBit(1'b0); sendBit(1'b0);
    checkOutput("after drop sym", sym, 3);
    expQ.push_back(3'd3);
    waitCycles(1);

    // Illegal third mask.
    m[2] = 8'h05;
    applyStimulus(0);
    checkOutput("illegal tbl_err cleared", tbl_err, 0);
    waitCycles(7);
    checkOutput("illegal tbl_err", tbl_err, 1);
    checkOutput("illegal tbl_ready", tbl_ready, 0);
    checkOutput("illegal bit_ready", bit_ready, 0);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    waitCycles(4);
    bit_valid = 1'b0;
    checkOutput("illegal bits ignored", sym_valid, 0);
    m[2] = 8'h07;
    applyStimulus(0);
    checkOutput("relegal tbl_err cleared", tbl_err, 0);
    waitCycles(7);
    checkOutput("relegal tbl_ready", tbl_ready, 1);

    // MAX_LEN=4 instance: 5-bit codes rejected, then a 4-bit table.
    applyStimulus(1);
    waitCycles(7);
    checkOutput("len4 long table tbl_err", tbl_err4, 1);
    checkOutput("len4 long table tbl_ready", tbl_ready4, 0);
    hc = shortHc; m = shortM;
    applyStimulus(1);
    waitCycles(7);
    checkOutput("len4 tbl_ready", tbl_ready4, 1);
    checkOutput("len4 tbl_err", tbl_err4, 0);
    sendBit4(1'b0); sendBit4(1'b0); sendBit4(1'b1);
    checkOutput("len4 dec_err after 3", dec_err4, 0);
    sendBit4(1'b0);
    checkOutput("len4 dec_err after 4", dec_err4, 1);
    checkOutput("len4 no sym", sym_valid4, 0);
    waitCycles(1);
    checkOutput("len4 dec_err pulse", dec_err4, 0);
    sendBit4(1'b1);
    checkOutput("len4 recover sym_valid", sym_valid4, 1);
    checkOutput("len4 recover sym", sym4, 1);
    hc = goodHc; m = goodM;

    // Asynchronous reset in the middle of a code.
    sendBit(1'b0);
    reset = 1'b0;
    #1;
    checkOutput("async reset tbl_ready", tbl_ready, 0);
    checkOutput("async reset bit_ready", bit_ready, 0);
    checkOutput("async reset sym_valid", sym_valid, 0);
    waitCycles(1);
    reset = 1'b1;
    applyStimulus(0);
    waitCycles(7);
    checkOutput("post reset tbl_ready", tbl_ready, 1);
    sendBit(1'b1);
    checkOutput("post reset sym", sym, 1);
    expQ.push_back(3'd1);
    waitCycles(1);

`ifdef HUFFMAN_DEC_CNT_EN
    applyStimulus(0);
    waitCycles(7);
    checkOutput("cnt cleared", cnt1, 0);
    for (int k = 0; k < 300; k++) begin
      sendBit(1'b1);
      expQ.push_back(3'd1);
    end
    waitCycles(2);
    checkOutput("cnt1 saturated", cnt1, 255);
    checkOutput("cnt2 untouched", cnt2, 0);
`endif

    waitCycles(3);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
